mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter for a single-port 16-bit memory (p0/p1 req/wr/addr/wdata in, done/rdata/err out; mem_* master side; busy status)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [15:0]           p0_wdata,
  output logic                  p0_done,
  output logic [15:0]           p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [15:0]           p1_wdata,
  output logic                  p1_done,
  output logic [15:0]           p1_rdata,
  output logic                  p1_err,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t state;
  logic [3:0] cnt;
  logic last, gnt, lwr;
  logic gsel, g_wr;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [15:0] g_wdata;
  always_comb begin
    gsel = (p0_req && p1_req) ? ~last : p1_req;
    g_wr = gsel ? p1_wr : p0_wr;
    g_addr = gsel ? p1_addr : p0_addr;
    g_wdata = gsel ? p1_wdata : p0_wdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      gnt <= 1'b0;
      lwr <= 1'b0;
      busy <= 1'b0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        IDLE: if (p0_req || p1_req) begin
          gnt <= gsel;
          last <= gsel;
          lwr <= g_wr;
          cnt <= CNT_INIT;
          busy <= 1'b1;
          if (g_addr[0]) begin
            state <= DONE;
            p0_done <= ~gsel;
            p1_done <= gsel;
            p0_err <= ~gsel;
            p1_err <= gsel;
          end else begin
            state <= BUSY;
            mem_en <= 1'b1;
            mem_addr <= g_addr;
            mem_wdata <= g_wdata;
            mem_wr <= g_wr && (CNT_INIT == 4'd0);
          end
        end
        BUSY: if (cnt == 4'd0) begin
          state <= DONE;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          mem_addr <= '0;
          mem_wdata <= '0;
          p0_done <= ~gnt;
          p1_done <= gnt;
          if (!lwr && !gnt) p0_rdata <= mem_rdata;
          if (!lwr && gnt) p1_rdata <= mem_rdata;
        end else begin
          cnt <= cnt - 4'd1;
          mem_wr <= lwr && (cnt == 4'd1);
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
